// File: rtl/dual_port_ram_fifo_ctrl.sv
// Pointer/flag controller turning a 16x8 dual-port RAM into a show-ahead FIFO.
// Ports: clk, rst_n (sync, active-low), push/push_data, pop/pop_data,
//   full, empty, almost_full, almost_empty, count,
//   RAM port A (ram_we_a, ram_addr_a, ram_din_a) used as the write port,
//   RAM port B (ram_we_b, ram_addr_b, ram_din_b, ram_dout_b) used read-only.
// Optional macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module dual_port_ram_fifo_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
`ifdef FIFO_ERR_FLAGS_EN
  output logic              overflow,
  output logic              underflow,
`endif
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_din_a,
  output logic              ram_we_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_din_b,
  input  logic [DATA_W-1:0] ram_dout_b
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_TH = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_TH = AEMPTY_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            wr_en;
  logic            rd_en;

  // Flags decode the registered count only.
  assign full         = (count == DEPTH);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);

  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;

  assign ram_we_a   = wr_en;
  assign ram_addr_a = wr_ptr[ADDR_W-1:0];
  assign ram_din_a  = push_data;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = rd_ptr[ADDR_W-1:0];
  assign ram_din_b  = '0;

  // Show-ahead: asynchronous RAM read of the head slot.
  assign pop_data = ram_dout_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ONE;
      if (rd_en) rd_ptr <= rd_ptr + ONE;
      if (wr_en && !rd_en)      count <= count + ONE;
      else if (!wr_en && rd_en) count <= count - ONE;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full) overflow  <= 1'b1;
      if (pop && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dual_port_ram_fifo_ctrl.sv
// Self-checking bench for dual_port_ram_fifo_ctrl with a behavioural
// 16x8 dual-port RAM and a queue scoreboard of expected FIFO contents.
module tb_dual_port_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       push;
  logic [7:0] push_data;
  logic       pop;
  logic [7:0] pop_data;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       ram_we_a, ram_we_b;
  logic [3:0] ram_addr_a, ram_addr_b;
  logic [7:0] ram_din_a, ram_din_b;
  logic [7:0] ram_dout_b;
`ifdef FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
`endif

  always #5 clk = ~clk;

  dual_port_ram_fifo_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .push_data    (push_data),
    .pop          (pop),
    .pop_data     (pop_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .ram_we_a     (ram_we_a),
    .ram_addr_a   (ram_addr_a),
    .ram_din_a    (ram_din_a),
    .ram_we_b     (ram_we_b),
    .ram_addr_b   (ram_addr_b),
    .ram_din_b    (ram_din_b),
    .ram_dout_b   (ram_dout_b)
  );

  // Behavioural RAM: synchronous write on port A, async read on port B.
  logic [7:0] mem [16];
  always @(posedge clk) if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
  assign ram_dout_b = mem[ram_addr_b];

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] sb [$];
  logic [3:0] m_wr = '0;
  logic [3:0] m_rd = '0;
  logic       m_ov = 1'b0;
  logic       m_uf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    int n;
    n = sb.size();
    check("count", 32'(count), 32'(n));
    check("empty", 32'(empty), 32'(n == 0));
    check("full", 32'(full), 32'(n == 16));
    check("almost_full", 32'(almost_full), 32'(n >= 12));
    check("almost_empty", 32'(almost_empty), 32'(n <= 4));
    check("ram_we_b", 32'(ram_we_b), 32'd0);
    check("ram_din_b", 32'(ram_din_b), 32'd0);
    check("ram_addr_b", 32'(ram_addr_b), 32'(m_rd));
    if (n > 0) check("pop_data", 32'(pop_data), 32'(sb[0]));
`ifdef FIFO_ERR_FLAGS_EN
    check("overflow", 32'(overflow), 32'(m_ov));
    check("underflow", 32'(underflow), 32'(m_uf));
`endif
  endtask

  // One clock: drive at negedge, check combinational RAM drive,
  // update the model, then check registered state after the edge.
  task automatic cycle(input logic rst, input logic ps,
                       input logic [7:0] d, input logic pp);
    logic wr_ok, rd_ok;
    @(negedge clk);
    rst_n = ~rst;
    push = ps;
    push_data = d;
    pop = pp;
    #1;
    wr_ok = ps && sb.size() < 16;
    rd_ok = pp && sb.size() > 0;
    if (!rst) begin
      check("ram_we_a", 32'(ram_we_a), 32'(wr_ok));
      if (wr_ok) begin
        check("ram_addr_a", 32'(ram_addr_a), 32'(m_wr));
        check("ram_din_a", 32'(ram_din_a), 32'(d));
      end
      if (rd_ok) check("pop_head", 32'(pop_data), 32'(sb[0]));
    end
    if (rst) begin
      sb.delete();
      m_wr = '0;
      m_rd = '0;
      m_ov = 1'b0;
      m_uf = 1'b0;
    end else begin
      if (ps && sb.size() == 16) m_ov = 1'b1;
      if (pp && sb.size() == 0)  m_uf = 1'b1;
      if (rd_ok) begin
        void'(sb.pop_front());
        m_rd++;
      end
      if (wr_ok) begin
        sb.push_back(d);
        m_wr++;
      end
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  initial begin
    rst_n = 1'b0;
    push = 1'b0;
    push_data = '0;
    pop = 1'b0;
    cycle(1, 0, 8'h00, 0);
    cycle(1, 0, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);

    cycle(0, 1, 8'hEA, 0);
    cycle(0, 1, 8'h12, 0);
    cycle(0, 1, 8'h32, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 1);

    for (int i = 0; i < 16; i++) cycle(0, 1, 8'(i), 0);
    cycle(0, 1, 8'hFF, 0);
    cycle(0, 1, 8'hFE, 1);
    cycle(0, 1, 8'h10, 0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 8'h00, 1);
    cycle(0, 0, 8'h00, 1);
    cycle(0, 1, 8'h55, 1);
    cycle(0, 0, 8'h00, 1);

    for (int i = 0; i < 8; i++) cycle(0, 1, 8'(8'hA0 + i), 0);
    for (int i = 0; i < 20; i++) cycle(0, 1, 8'($urandom_range(0, 255)), 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 1);

    cycle(1, 1, 8'hBD, 0);
    cycle(0, 1, 8'h5A, 0);
    cycle(0, 1, 8'hC3, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
